// File: rtl/led_state_machine_if.sv
// Purpose: carries the one-hot process-status LED bus from the scheduler to whatever drives the pins.
// Latency: none, this is wiring only.
// Backpressure: none; the LED bus is a plain level-valued output with no handshake.
//
// Signals:
//   out_led [2:0] : one-hot active-process LEDs (bit0 = process 1, bit1 = process 2, bit2 = process 3)
// Modports:
//   master : producer side (the scheduler drives out_led)
//   slave  : consumer side (reads out_led)
interface led_state_machine_if;
    logic [2:0] out_led;

    modport master (output out_led);
    modport slave  (input  out_led);
endinterface

// File: rtl/led_state_machine.sv
// Purpose: three periodic request generators arbitrated by a 4-state FSM; the granted process is shown one-hot on out_led.
// Latency: one clock from a request level change to the LED change (grant and release).
// Backpressure: none; requests that rise and fall while another process is granted are dropped.
//
// Ports:
//   clk  : single clock, rising edge active
//   kill : asynchronous active-low reset (clears counters, state and LEDs immediately)
//   led  : led_state_machine_if master modport carrying out_led[2:0]
module led_state_machine #(
    parameter int P1_PERIOD = 70,
    parameter int P1_HIGH   = 20,
    parameter int P2_PERIOD = 90,
    parameter int P2_HIGH   = 10,
    parameter int P3_PERIOD = 34,
    parameter int P3_HIGH   = 4
) (
    input  logic                   clk,
    input  logic                   kill,
    led_state_machine_if.master    led
);

    // ------------------------------------------------------------------
    // Request generators: free-running modulo counters; each request is
    // high for the last Pn_HIGH counts of its period.
    // ------------------------------------------------------------------
    localparam int C1_W = $clog2(P1_PERIOD);
    localparam int C2_W = $clog2(P2_PERIOD);
    localparam int C3_W = $clog2(P3_PERIOD);

    localparam logic [C1_W-1:0] C1_LAST = C1_W'(P1_PERIOD - 1);
    localparam logic [C2_W-1:0] C2_LAST = C2_W'(P2_PERIOD - 1);
    localparam logic [C3_W-1:0] C3_LAST = C3_W'(P3_PERIOD - 1);

    localparam logic [C1_W-1:0] C1_ON = C1_W'(P1_PERIOD - P1_HIGH);
    localparam logic [C2_W-1:0] C2_ON = C2_W'(P2_PERIOD - P2_HIGH);
    localparam logic [C3_W-1:0] C3_ON = C3_W'(P3_PERIOD - P3_HIGH);

    logic [C1_W-1:0] cnt_1;
    logic [C2_W-1:0] cnt_2;
    logic [C3_W-1:0] cnt_3;
    logic            req_1;
    logic            req_2;
    logic            req_3;

    always_ff @(posedge clk or negedge kill) begin
        if (!kill) begin
            cnt_1 <= '0;
        end else if (cnt_1 == C1_LAST) begin
            cnt_1 <= '0;
        end else begin
            cnt_1 <= cnt_1 + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge kill) begin
        if (!kill) begin
            cnt_2 <= '0;
        end else if (cnt_2 == C2_LAST) begin
            cnt_2 <= '0;
        end else begin
            cnt_2 <= cnt_2 + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge kill) begin
        if (!kill) begin
            cnt_3 <= '0;
        end else if (cnt_3 == C3_LAST) begin
            cnt_3 <= '0;
        end else begin
            cnt_3 <= cnt_3 + 1'b1;
        end
    end

    assign req_1 = (cnt_1 >= C1_ON);
    assign req_2 = (cnt_2 >= C2_ON);
    assign req_3 = (cnt_3 >= C3_ON);

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_PROC1 = 2'b01;
    localparam logic [1:0] S_PROC2 = 2'b10;
    localparam logic [1:0] S_PROC3 = 2'b11;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [2:0] led_q;
    logic [2:0] led_d;

    // A granted process holds the grant until its own request drops; there
    // is no PROCx->PROCy arc, so every grant is preceded by an IDLE cycle.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (req_1) begin
                    state_d = S_PROC1;
                end else if (req_2) begin
                    state_d = S_PROC2;
                end else if (req_3) begin
                    state_d = S_PROC3;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PROC1: state_d = req_1 ? S_PROC1 : S_IDLE;
            S_PROC2: state_d = req_2 ? S_PROC2 : S_IDLE;
            S_PROC3: state_d = req_3 ? S_PROC3 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // LEDs are decoded from the next state and registered alongside the
    // state register, so they track the state without an extra cycle of lag
    // and still come straight from flops (glitch-free).
    always_comb begin
        led_d = 3'b000;
        case (state_d)
            S_PROC1: led_d = 3'b001;
            S_PROC2: led_d = 3'b010;
            S_PROC3: led_d = 3'b100;
            default: led_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge kill) begin
        if (!kill) begin
            state_q <= S_IDLE;
            led_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
        end
    end

    assign led.out_led = led_q;

endmodule

// File: tb/tb_led_state_machine.sv
// Purpose: self-checking bench for led_state_machine: expected LED timeline table, scoreboard queue, continuous invariants.
// Latency: checks each edge's expected value half a clock after that edge.
// Backpressure: not applicable; the DUT has no handshake.
module tb_led_state_machine;

    logic clk;
    logic kill;

    led_state_machine_if led_bus ();

    led_state_machine #(
        .P1_PERIOD (70),
        .P1_HIGH   (20),
        .P2_PERIOD (90),
        .P2_HIGH   (10),
        .P3_PERIOD (34),
        .P3_HIGH   (4)
    ) dut (
        .clk  (clk),
        .kill (kill),
        .led  (led_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected LED timeline after reset release: edges first..last show led.
    typedef struct {
        int         first;
        int         last;
        logic [2:0] led;
    } seg_t;

    seg_t segs[19];

    typedef struct {
        int         edge_k;
        logic [2:0] led;
    } exp_t;

    exp_t sb_q[$];

    task automatic check3(input string name, input int edge_k,
                          input logic [2:0] got, input logic [2:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s edge=%0d got=%b want=%b", name, edge_k, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic logic [2:0] expected_at(input int k);
        logic [2:0] r;
        r = 3'bxxx;
        for (int i = 0; i < 19; i++) begin
            if (k >= segs[i].first && k <= segs[i].last) r = segs[i].led;
        end
        return r;
    endfunction

    // Push the expected value when an edge happens, pop and compare half a
    // cycle later.
    task automatic run_table(input int first, input int last);
        exp_t e;
        for (int k = first; k <= last; k++) begin
            @(posedge clk);
            e.edge_k = k;
            e.led    = expected_at(k);
            sb_q.push_back(e);
            @(negedge clk);
            if (sb_q.size() == 0) begin
                check_int("scoreboard_empty", 0, 1);
            end else begin
                e = sb_q.pop_front();
                check3("timeline", e.edge_k, led_bus.out_led, e.led);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Continuous invariants: at most one LED, each high run no longer than
    // its Pn_HIGH, and every high run entered from 000.
    // ------------------------------------------------------------------
    logic [2:0] mon_prev = 3'b000;
    int         mon_run  = 0;

    function automatic int high_limit(input logic [2:0] l);
        case (l)
            3'b001:  return 20;
            3'b010:  return 10;
            3'b100:  return 4;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!kill) begin
            mon_prev = 3'b000;
            mon_run  = 0;
        end else begin
            checks++;
            if ($countones(led_bus.out_led) > 1) begin
                errors++;
                $display("FAIL onehot got=%b want=at most one bit", led_bus.out_led);
            end
            if (led_bus.out_led != 3'b000) begin
                if (led_bus.out_led == mon_prev) begin
                    mon_run++;
                end else begin
                    checks++;
                    if (mon_prev != 3'b000) begin
                        errors++;
                        $display("FAIL idle_gap got=%b->%b want=000 between grants",
                                 mon_prev, led_bus.out_led);
                    end
                    mon_run = 1;
                end
                checks++;
                if (mon_run > high_limit(led_bus.out_led)) begin
                    errors++;
                    $display("FAIL high_len led=%b got=%0d want<=%0d",
                             led_bus.out_led, mon_run, high_limit(led_bus.out_led));
                end
            end else begin
                mon_run = 0;
            end
            mon_prev = led_bus.out_led;
        end
    end

    initial begin
        exp_t e;
        segs[0]  = '{1,   30,  3'b000};
        segs[1]  = '{31,  34,  3'b100};   // first process 3 pulse
        segs[2]  = '{35,  50,  3'b000};
        segs[3]  = '{51,  70,  3'b001};   // P3 pulse at 64..67 is dropped
        segs[4]  = '{71,  80,  3'b000};
        segs[5]  = '{81,  90,  3'b010};
        segs[6]  = '{91,  98,  3'b000};
        segs[7]  = '{99,  102, 3'b100};
        segs[8]  = '{103, 120, 3'b000};
        segs[9]  = '{121, 140, 3'b001};   // P3 pulse at 132..135 dropped
        segs[10] = '{141, 166, 3'b000};
        segs[11] = '{167, 170, 3'b100};
        segs[12] = '{171, 171, 3'b000};   // one-cycle gap before back-to-back P2
        segs[13] = '{172, 180, 3'b010};
        segs[14] = '{181, 190, 3'b000};
        segs[15] = '{191, 210, 3'b001};
        segs[16] = '{211, 234, 3'b000};
        segs[17] = '{235, 238, 3'b100};
        segs[18] = '{239, 259, 3'b000};

        // Reset held for 5 cycles.
        kill = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check3("reset_led", 0, led_bus.out_led, 3'b000);
        check_int("reset_cnt_1", int'(dut.cnt_1), 0);
        check_int("reset_cnt_2", int'(dut.cnt_2), 0);
        check_int("reset_cnt_3", int'(dut.cnt_3), 0);

        kill = 1'b1;
        run_table(1, 259);

        // Long free run for the invariant monitor.
        repeat (5000) @(negedge clk);

        // Mid-operation reset while PROC1 is active.
        kill = 1'b0;
        repeat (3) @(negedge clk);
        kill = 1'b1;
        run_table(1, 59);
        @(posedge clk);
        e.edge_k = 60;
        e.led    = 3'b001;
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        check3("proc1_before_kill", e.edge_k, led_bus.out_led, e.led);
        kill = 1'b0;
        #1;
        check3("async_kill_led", 60, led_bus.out_led, 3'b000);
        check_int("async_kill_cnt_1", int'(dut.cnt_1), 0);
        check_int("async_kill_cnt_3", int'(dut.cnt_3), 0);
        repeat (3) @(negedge clk);
        check3("kill_held_led", 60, led_bus.out_led, 3'b000);
        kill = 1'b1;
        run_table(1, 110);

        check_int("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
